draw_pair_fetch: RTL and testbench

Downstream stage of the draw address counter. Consumes even/odd address pairs, issues one dual-port memory read per pair, packs the two returned bytes into one 16-bit word, and buffers words in a small FIFO toward the pixel/display sink with valid/ready backpressure. Asserts `done` once the final pair of the frame region has been delivered.

---
 rtl/draw_pkg.sv | 18 +
 rtl/draw_pair_fetch_if.sv | 32 +++
 rtl/draw_pair_fifo.sv | 46 ++++
 rtl/draw_pair_fetch.sv | 100 ++++++++++
 tb/tb_draw_pair_fetch.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/draw_pkg.sv
// Shared types and defaults for the draw pair fetch stage: FSM states,
// region end address and the packed FIFO word.
package draw_pkg;

  localparam int ADDR_W_DEF     = 14;
  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam logic [ADDR_W_DEF-1:0] LAST_ADDR_A_DEF = 14'd11518;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} draw_state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_W_DEF-1:0] data_b;
    logic [DATA_W_DEF-1:0] data_a;
  } pair_word_t;

endpackage

// File: rtl/draw_pair_fetch_if.sv
// Address-pair input, dual-port memory read and packed-word output buses.
// slave is the fetch block; master is the surrounding upstream/memory/sink.
interface draw_pair_fetch_if import draw_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_W-1:0]     addr_a;
  logic [ADDR_W-1:0]     addr_b;
  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_addr_a;
  logic [ADDR_W-1:0]     mem_addr_b;
  logic [DATA_W-1:0]     mem_data_a;
  logic [DATA_W-1:0]     mem_data_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   out_data;
  logic                  out_last;

  modport slave (
    input  in_valid, addr_a, addr_b, mem_data_a, mem_data_b, out_ready,
    output in_ready, mem_rd_en, mem_addr_a, mem_addr_b,
           out_valid, out_data, out_last
  );

  modport master (
    output in_valid, addr_a, addr_b, mem_data_a, mem_data_b, out_ready,
    input  in_ready, mem_rd_en, mem_addr_a, mem_addr_b,
           out_valid, out_data, out_last
  );
endinterface

// File: rtl/draw_pair_fifo.sv
// Shift-register FIFO of pair_word_t: the head always sits in entry 0, so
// the output word and its valid come straight from flops.
module draw_pair_fifo import draw_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  pair_word_t                 din,
  input  logic                       pop,
  output pair_word_t                 dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  pair_word_t      mem [DEPTH];
  logic            push_ok;
  logic [CW-1:0]   cnt_nxt;
  logic [AW-1:0]   widx;

  // With a simultaneous pop the new word lands one slot lower.
  always_comb begin
    push_ok = push && (pop || (count < CW'(DEPTH)));
    cnt_nxt = count + CW'(push_ok) - CW'(pop);
    widx    = pop ? AW'(count - CW'(1)) : AW'(count);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      dout_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop)
        for (int i = 0; i < DEPTH-1; i++) mem[i] <= mem[i+1];
      if (push_ok) mem[widx] <= din;
      count      <= cnt_nxt;
      dout_valid <= (cnt_nxt != '0);
    end
  end

  assign dout = mem[0];

endmodule

// File: rtl/draw_pair_fetch.sv
// Reads one even/odd byte pair per accepted address pair and queues the packed
// word toward the sink. Optional pairing check: define DRAW_PAIR_CHECK_EN.
module draw_pair_fetch import draw_pkg::*; #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] LAST_ADDR_A = ADDR_W'(LAST_ADDR_A_DEF)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  draw_pair_fetch_if.slave        bus,
  output logic                    done,
  output logic                    pair_err
);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  draw_state_t       state;
  logic              inflight, last_q;
  logic              in_ready_i, accept, is_last, pop, start_ok;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credits;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              fifo_valid;
  pair_word_t        push_word, head;

  // Credits cover both buffered words and the read in flight, so the FIFO
  // can never be pushed while full.
  assign credits    = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign in_ready_i = (state == RUN) && (credits < (CW+1)'(FIFO_DEPTH));
  assign accept     = bus.in_valid && in_ready_i;
  assign is_last    = (bus.addr_a == LAST_ADDR_A);
  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign pop        = fifo_valid && bus.out_ready;

  assign bus.in_ready   = in_ready_i;
  assign bus.mem_rd_en  = accept;
  assign bus.mem_addr_a = accept ? bus.addr_a : '0;
  assign bus.mem_addr_b = accept ? bus.addr_b : '0;

  assign rd_a      = bus.mem_data_a;
  assign rd_b      = bus.mem_data_b;
  assign push_word = '{last: last_q, data_b: rd_b, data_a: rd_a};

  draw_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight),
    .din        (push_word),
    .pop        (pop),
    .dout       (head),
    .dout_valid (fifo_valid),
    .count      (fifo_count)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = {head.data_b, head.data_a};
  assign bus.out_last  = head.last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      inflight <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      inflight <= accept;
      last_q   <= accept && is_last;
      case (state)
        IDLE:  if (start_ok) state <= RUN;
        RUN:   if (accept && is_last) state <= DRAIN;
        // Leave on the pop that empties the FIFO so done follows it by one cycle.
        DRAIN: if (!inflight && ((fifo_count == '0) ||
                                 ((fifo_count == CW'(1)) && pop))) begin
                 state <= DONE;
                 done  <= 1'b1;
               end
        DONE:  if (start_ok) begin
                 state <= RUN;
                 done  <= 1'b0;
               end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRAW_PAIR_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pair_err <= 1'b0;
    else if (start_ok)
      pair_err <= 1'b0;
    else if (accept && (bus.addr_a[0] || (bus.addr_b != bus.addr_a + ADDR_W'(1))))
      pair_err <= 1'b1;
  end
`else
  assign pair_err = 1'b0;
`endif

endmodule

// File: tb/tb_draw_pair_fetch.sv
// Directed/random bench for draw_pair_fetch against a queue-based reference
// of accepted pairs, output word timing, done and pair error.
module tb_draw_pair_fetch;

  localparam int          NPAIR  = 128;
  localparam int          DEPTH  = 4;
  localparam logic [13:0] BASE   = 14'd11264;
  localparam logic [13:0] LAST   = 14'd11518;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  typedef struct {
    logic [15:0] d;
    logic        last;
    int          rdy;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       done, pair_err;
  logic [7:0] salt = 8'h00;

  draw_pair_fetch_if bus();

  draw_pair_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus.slave),
    .done     (done),
    .pair_err (pair_err)
  );

  always #5 clk = ~clk;

  // Memory: byte at an address is its low 8 bits xor a per-run salt.
  always @(posedge clk)
    if (bus.mem_rd_en) begin
      bus.mem_data_a <= bus.mem_addr_a[7:0] ^ salt;
      bus.mem_data_b <= bus.mem_addr_b[7:0] ^ salt;
    end

  ent_t q[$];
  int   mode = M_IDLE;
  bit   done_m = 1'b0, err_m = 1'b0, acc_m = 1'b0;
  int   cyc = 0, n_vec = 0, n_err = 0, acc_obs = 0, pop_obs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit st, input bit v, input logic [13:0] a, input logic [13:0] b,
                      input bit r);
    bit rdy_e, ov_e, st_ok;
    @(negedge clk);
    start = st; bus.in_valid = v; bus.addr_a = a; bus.addr_b = b; bus.out_ready = r;
    #1;
    rdy_e = (mode == M_RUN) && (q.size() < DEPTH);
    acc_m = v && rdy_e;
    ov_e  = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("in_ready",   bus.in_ready,   rdy_e);
    chk("mem_rd_en",  bus.mem_rd_en,  acc_m);
    chk("mem_addr_a", bus.mem_addr_a, acc_m ? a : 14'd0);
    chk("mem_addr_b", bus.mem_addr_b, acc_m ? b : 14'd0);
    chk("out_valid",  bus.out_valid,  ov_e);
    if (ov_e) begin
      chk("out_data", bus.out_data, q[0].d);
      chk("out_last", bus.out_last, q[0].last);
    end
    chk("done",     done,     done_m);
    chk("pair_err", pair_err, err_m);
    if (bus.in_valid && bus.in_ready) acc_obs++;
    if (bus.out_valid && r) pop_obs++;
    st_ok = st && (mode == M_IDLE || mode == M_DONE);
    if (ov_e && r) begin
      if (q[0].last) begin mode = M_DONE; done_m = 1'b1; end
      void'(q.pop_front());
    end
    if (acc_m) begin
      q.push_back(ent_t'{d: {b[7:0] ^ salt, a[7:0] ^ salt}, last: (a == LAST), rdy: cyc + 2});
      if (a == LAST) mode = M_DRAIN;
`ifdef DRAW_PAIR_CHECK_EN
      if (a[0] || (b != a + 14'd1)) err_m = 1'b1;
`endif
    end
    if (st_ok) begin mode = M_RUN; done_m = 1'b0; err_m = 1'b0; end
    cyc++;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready,   0);
    chk({tag, "_mem_rd_en"}, bus.mem_rd_en,  0);
    chk({tag, "_mem_addr"},  {bus.mem_addr_b, bus.mem_addr_a}, 0);
    chk({tag, "_out_valid"}, bus.out_valid,  0);
    chk({tag, "_out_data"},  bus.out_data,   0);
    chk({tag, "_out_last"},  bus.out_last,   0);
    chk({tag, "_done"},      done,           0);
    chk({tag, "_pair_err"},  pair_err,       0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #2;
    reset = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
    #1;
    reset_checks("midrst");
    q.delete(); mode = M_IDLE; done_m = 1'b0; err_m = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [13:0] pa(input int i);
    return BASE + 14'(2 * i);
  endfunction

  task automatic run_region(input logic [7:0] s, input bit rnd, input int bad);
    int idx = 0, guard = 0;
    logic [13:0] a, b;
    bit v, r;
    salt = s; pop_obs = 0;
    step(1'b1, 1'b0, 14'd0, 14'd0, 1'b1);
    while (idx < NPAIR && guard < 4000) begin
      a = pa(idx); b = a + 14'd1;
      if (idx == bad) begin a = 14'd11265; b = 14'd11266; end
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      step(1'b0, v, a, b, r);
      if (acc_m) idx++;
      guard++;
    end
    while (!done_m && guard < 4000) begin
      r = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      step(1'b0, 1'b0, 14'd0, 14'd0, r);
      guard++;
    end
    step(1'b0, 1'b0, 14'd0, 14'd0, 1'b1);
    chk("region_words", pop_obs, NPAIR);
    chk("region_done",  done,    1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int pidx;
    bus.in_valid = 1'b0; bus.addr_a = '0; bus.addr_b = '0; bus.out_ready = 1'b0;
    bus.mem_data_a = '0; bus.mem_data_b = '0;
    #1;
    reset_checks("por");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Full region at full rate: first word 16'h0100, last 16'hFFFE.
    run_region(8'h00, 1'b0, -1);

    // Restart from DONE with random valid/ready and different data.
    run_region(8'($urandom), 1'b1, -1);

    // Backpressure: only DEPTH pairs get in while the sink stalls.
    salt = 8'($urandom);
    step(1'b1, 1'b0, 14'd0, 14'd0, 1'b0);
    acc_obs = 0; pidx = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, pa(pidx), pa(pidx) + 14'd1, 1'b0);
      if (acc_m) pidx++;
    end
    chk("bp_accepts", acc_obs, 4);
    chk("bp_in_ready", bus.in_ready, 0);
    // One pop at full frees exactly one credit.
    step(1'b0, 1'b1, pa(pidx), pa(pidx) + 14'd1, 1'b1);
    if (acc_m) pidx++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, pa(pidx), pa(pidx) + 14'd1, 1'b0);
      if (acc_m) pidx++;
    end
    chk("refill_accepts", acc_obs, 5);
    for (int i = 0; i < 40 && acc_obs < 10; i++) begin
      step(1'b0, 1'b1, pa(pidx), pa(pidx) + 14'd1, 1'b1);
      if (acc_m) pidx++;
    end
    chk("pre_reset_accepts", acc_obs, 10);

    // Reset mid-run, then nothing moves without a new start.
    reset_dut();
    pop_obs = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, pa(i), pa(i) + 14'd1, 1'b1);
    chk("post_reset_words", pop_obs, 0);

    // Region containing a mis-paired address; start afterwards clears the flag.
    run_region(8'($urandom), 1'b1, 5);
    step(1'b1, 1'b0, 14'd0, 14'd0, 1'b1);
    step(1'b0, 1'b0, 14'd0, 14'd0, 1'b1);
    step(1'b0, 1'b0, 14'd0, 14'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
